// File: rtl/stat_counter_bank.sv
// Multi-channel statistics counter bank: per-channel variable increments, wrap or saturate,
// sticky overflow, atomic snapshot into a shadow bank and a registered control-plane read port.
module stat_counter_bank #(
    parameter int Channels    = 4,
    parameter int Width       = 32,
    parameter int IncWidth    = 16,
    parameter int Saturate    = 0,
    parameter int ClearOnSnap = 0,
    localparam int SelW       = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [Channels-1:0]          inc_valid_i,
    input  logic [Channels*IncWidth-1:0] inc_amt_i,
    input  logic                         clr_i,
    input  logic                         snap_i,
    input  logic                         rd_req_i,
    input  logic [SelW-1:0]              rd_sel_i,
    output logic [Width-1:0]             rd_data_o,
    output logic                         rd_valid_o,
    output logic [Channels-1:0]          ovf_o
);

    localparam logic [Width-1:0] AllOnes = {Width{1'b1}};
    localparam logic [Width-1:0] Zero    = {Width{1'b0}};

    logic [Width-1:0]    live_q   [Channels];
    logic [Width-1:0]    live_d   [Channels];
    logic [Width-1:0]    shadow_q [Channels];
    logic [Width-1:0]    shadow_d [Channels];
    logic [Width-1:0]    amt_s    [Channels];
    logic [Width:0]      sum_s    [Channels];
    logic [Channels-1:0] ovf_q;
    logic [Channels-1:0] ovf_d;
    logic [Width-1:0]    rd_mux_s;
    logic [Width-1:0]    rd_data_q;
    logic [Width-1:0]    rd_data_d;
    logic                rd_valid_q;
    logic                rd_valid_d;

    // Per-channel next state: one Width+1 bit adder, clear beats snapshot-restart beats increment.
    always_comb begin
        ovf_d = ovf_q;
        for (int n = 0; n < Channels; n++) begin
            // Gating the amount by its strobe lets the idle case share the same adder (adds zero).
            amt_s[n]    = inc_valid_i[n] ? Width'(inc_amt_i[n*IncWidth +: IncWidth]) : Zero;
            sum_s[n]    = {1'b0, live_q[n]} + {1'b0, amt_s[n]};
            shadow_d[n] = snap_i ? live_q[n] : shadow_q[n];
            if (clr_i) begin
                live_d[n] = Zero;
                ovf_d[n]  = 1'b0;
            end else if (snap_i && (ClearOnSnap != 0)) begin
                live_d[n] = amt_s[n];
                ovf_d[n]  = 1'b0;
            end else if (sum_s[n][Width]) begin
                live_d[n] = (Saturate != 0) ? AllOnes : sum_s[n][Width-1:0];
                ovf_d[n]  = 1'b1;
            end else begin
                live_d[n] = sum_s[n][Width-1:0];
                ovf_d[n]  = ovf_q[n];
            end
        end
    end

    // Shadow read mux; an unmatched (out-of-range) select leaves the result at zero.
    always_comb begin
        rd_mux_s = Zero;
        for (int n = 0; n < Channels; n++) begin
            rd_mux_s = rd_mux_s | (shadow_q[n] & {Width{rd_sel_i == SelW'(n)}});
        end
        rd_valid_d = rd_req_i;
        rd_data_d  = rd_req_i ? rd_mux_s : rd_data_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < Channels; n++) begin
                live_q[n]   <= Zero;
                shadow_q[n] <= Zero;
            end
            ovf_q      <= {Channels{1'b0}};
            rd_data_q  <= Zero;
            rd_valid_q <= 1'b0;
        end else begin
            for (int n = 0; n < Channels; n++) begin
                live_q[n]   <= live_d[n];
                shadow_q[n] <= shadow_d[n];
            end
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign ovf_o      = ovf_q;

endmodule
